// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with programmable fetch latency
// Valid/ready fetch port, program-load write port, misaligned/out-of-range error flagging.
module imem_responder #(
   parameter int                  DATA_LEN   = 32,
   parameter int                  DEPTH_LOG2 = 10,
   parameter int                  LATENCY    = 1,
   parameter logic [DATA_LEN-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter logic [DATA_LEN-1:0] NOP_INST   = 32'h0000_0013
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_LEN-1:0]   req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_LEN-1:0]   rsp_inst,
   output logic                  rsp_err,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [DATA_LEN-1:0]   load_data,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
   localparam logic       LAT_ONE = (LATENCY == 1);

   state_t                state;
   logic [3:0]            cnt;
   logic [DEPTH_LOG2-1:0] pend_idx;
   logic                  pend_err;
   logic [DATA_LEN-1:0]   mem [DEPTH];

   logic [DATA_LEN-1:0]   offset;
   logic [1:0]            addr_lsb;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  acc_err;
   logic                  accept;
   logic                  capture;
   logic [DEPTH_LOG2-1:0] cap_idx;
   logic                  cap_err;

   // Addresses below BASE_ADDR wrap to huge offsets and fall into the range error.
   assign offset   = req_addr - BASE_ADDR;
   assign addr_lsb = offset[1:0] + BASE_ADDR[1:0];
   assign acc_idx  = offset[DEPTH_LOG2+1:2];
   assign acc_err  = (addr_lsb != 2'b00) || (offset[DATA_LEN-1:DEPTH_LOG2+2] != '0);

   always_comb begin
      req_ready = 1'b0;
      if (!load_en) begin
         case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = rsp_ready;
            default: req_ready = 1'b0;
         endcase
      end
   end

   assign accept  = req_valid && req_ready;
   assign capture = (accept && LAT_ONE) || (state == WAIT && cnt == 4'd1);
   assign cap_idx = (state == WAIT) ? pend_idx : acc_idx;
   assign cap_err = (state == WAIT) ? pend_err : acc_err;
   assign busy    = (state != IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pend_idx  <= '0;
         pend_err  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_inst  <= NOP_INST;
      end else begin
         // Registered read: a load on this same edge lands after the read (old word wins).
         if (capture) begin
            rsp_inst <= cap_err ? NOP_INST : mem[cap_idx];
            rsp_err  <= cap_err;
         end
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  pend_idx  <= acc_idx;
                  pend_err  <= acc_err;
                  cnt       <= LAT_M1;
                  rsp_valid <= LAT_ONE;
                  state     <= LAT_ONE ? RESP : WAIT;
               end else if (state == RESP && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (load_en)
         mem[load_addr] <= load_data;
   end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
// Instance 0 runs LATENCY=1, instance 1 runs LATENCY=3; responses are checked against a scoreboard.
module tb_imem_responder;

   typedef struct { logic [31:0] inst; logic err; } exp_t;
   typedef struct { logic [31:0] addr; logic [31:0] inst; logic err; } vec_t;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
   logic [1:0][31:0] req_addr, rsp_inst;
   logic             load_en;
   logic [9:0]       load_addr;
   logic [31:0]      load_data;

   int   checks = 0;
   int   failures = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t mon_e;
   vec_t vecs[8];

   always #5 sys_clk = ~sys_clk;

   imem_responder #(.LATENCY(1)) dut_l1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_inst(rsp_inst[0]),
      .rsp_err(rsp_err[0]), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy[0])
   );

   imem_responder #(.LATENCY(3)) dut_l3 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_inst(rsp_inst[1]),
      .rsp_err(rsp_err[1]), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push(input int d, input logic [31:0] i, input logic e);
      if (d == 0) sb0.push_back('{inst: i, err: e});
      else        sb1.push_back('{inst: i, err: e});
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] v);
      load_en = 1'b1; load_addr = a; load_data = v;
      tick();
      load_en = 1'b0;
   endtask

   // Issue one request from IDLE and return in the first cycle rsp_valid is seen.
   task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] inst, input logic e);
      int lat;
      int k;
      lat = (d == 0) ? 1 : 3;
      req_valid[d] = 1'b1;
      req_addr[d]  = addr;
      #1 chkb("req_ready_idle", req_ready[d], 1'b1);
      push(d, inst, e);
      tick();
      req_valid[d] = 1'b0;
      k = 1;
      while (!rsp_valid[d] && k < 20) begin
         chkb("req_ready_wait", req_ready[d], 1'b0);
         tick();
         k++;
      end
      chk("latency", k, lat);
   endtask

   task automatic retire(input int d);
      tick();
      chkb("rsp_valid_drop", rsp_valid[d], 1'b0);
      chkb("busy_drop", busy[d], 1'b0);
   endtask

   always @(negedge sys_clk) begin
      for (int d = 0; d < 2; d++) begin
         if (sys_rst_n && rsp_valid[d] && rsp_ready[d]) begin
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
               chkb("unexpected_rsp", rsp_valid[d], 1'b0);
            end else begin
               if (d == 0) mon_e = sb0.pop_front();
               else        mon_e = sb1.pop_front();
               chk("rsp_inst", rsp_inst[d], mon_e.inst);
               chkb("rsp_err", rsp_err[d], mon_e.err);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0};
      vecs[1] = '{32'h8000_0004, 32'h0000_0073, 1'b0};
      vecs[2] = '{32'h8000_0002, 32'h0000_0013, 1'b1};
      vecs[3] = '{32'h8000_1000, 32'h0000_0013, 1'b1};
      vecs[4] = '{32'h8000_0FFC, 32'h0000_006F, 1'b0};
      vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0013, 1'b1};
      vecs[6] = '{32'h8000_1002, 32'h0000_0013, 1'b1};
      vecs[7] = '{32'h8000_0008, 32'h0020_0113, 1'b0};

      sys_rst_n = 1'b0;
      req_valid = '0; rsp_ready = 2'b11; req_addr = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (3) tick();
      chk("reset_inst_in_rst", rsp_inst[0], 32'h13);
      sys_rst_n = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         chkb("reset_rsp_valid", rsp_valid[d], 1'b0);
         chk("reset_rsp_inst", rsp_inst[d], 32'h13);
         chkb("reset_rsp_err", rsp_err[d], 1'b0);
         chkb("reset_req_ready", req_ready[d], 1'b1);
         chkb("reset_busy", busy[d], 1'b0);
      end

      load(10'd0, 32'h0010_0093);
      load(10'd1, 32'h0000_0073);
      load(10'd2, 32'h0020_0113);
      load(10'd3, 32'h0030_0193);
      load(10'd4, 32'h0040_0213);
      load(10'd5, 32'h0050_0293);
      load(10'd1023, 32'h0000_006F);

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 8; i++) begin
            fetch(d, vecs[i].addr, vecs[i].inst, vecs[i].err);
            retire(d);
         end

      // Response held under backpressure on the LATENCY=3 instance.
      rsp_ready[1] = 1'b0;
      fetch(1, 32'h8000_0004, 32'h0000_0073, 1'b0);
      repeat (4) begin
         tick();
         chkb("hold_valid", rsp_valid[1], 1'b1);
         chk("hold_inst", rsp_inst[1], 32'h0000_0073);
         chkb("hold_busy", busy[1], 1'b1);
         chkb("hold_req_ready", req_ready[1], 1'b0);
      end
      rsp_ready[1] = 1'b1;
      retire(1);

      // Back-to-back on the LATENCY=1 instance: no bubble.
      req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0000; push(0, 32'h0010_0093, 1'b0);
      tick();
      chkb("b2b_valid0", rsp_valid[0], 1'b1);
      req_addr[0] = 32'h8000_0004; push(0, 32'h0000_0073, 1'b0);
      #1 chkb("b2b_req_ready", req_ready[0], 1'b1);
      tick();
      chkb("b2b_valid1", rsp_valid[0], 1'b1);
      req_addr[0] = 32'h8000_0008; push(0, 32'h0020_0113, 1'b0);
      tick();
      chkb("b2b_valid2", rsp_valid[0], 1'b1);
      req_valid[0] = 1'b0;
      tick();
      chkb("b2b_valid_end", rsp_valid[0], 1'b0);

      // Load blocks accept in IDLE.
      load_en = 1'b1; load_addr = 10'd5; load_data = 32'h1111_1111;
      req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0000;
      #1 chkb("load_blocks_ready", req_ready[0], 1'b0);
      tick();
      load_en = 1'b0; req_valid[0] = 1'b0;
      chkb("load_no_accept_busy", busy[0], 1'b0);
      chkb("load_no_accept_valid", rsp_valid[0], 1'b0);

      // Load to the pending index during WAIT is visible.
      req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0010; push(1, 32'hAAAA_0001, 1'b0);
      tick();
      req_valid[1] = 1'b0;
      load_en = 1'b1; load_addr = 10'd4; load_data = 32'hAAAA_0001;
      tick();
      load_en = 1'b0;
      tick();
      chkb("wait_load_valid", rsp_valid[1], 1'b1);
      retire(1);

      // Load on the RESP-entry edge returns the old word.
      req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0014; push(1, 32'h1111_1111, 1'b0);
      tick();
      req_valid[1] = 1'b0;
      tick();
      load_en = 1'b1; load_addr = 10'd5; load_data = 32'hBBBB_0002;
      tick();
      load_en = 1'b0;
      chkb("entry_load_valid", rsp_valid[1], 1'b1);
      retire(1);
      fetch(1, 32'h8000_0014, 32'hBBBB_0002, 1'b0);
      retire(1);

      // Asynchronous reset drops outstanding requests.
      rsp_ready[0] = 1'b0;
      req_valid = 2'b11;
      req_addr[0] = 32'h8000_0008;
      req_addr[1] = 32'h8000_0000;
      tick();
      req_valid = 2'b00;
      chkb("pre_rst_valid", rsp_valid[0], 1'b1);
      chkb("pre_rst_busy", busy[1], 1'b1);
      #2 sys_rst_n = 1'b0;
      #1;
      chkb("rst_async_valid", rsp_valid[0], 1'b0);
      chk("rst_async_inst", rsp_inst[0], 32'h13);
      chkb("rst_async_busy0", busy[0], 1'b0);
      chkb("rst_async_busy1", busy[1], 1'b0);
      rsp_ready = 2'b11;
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
      repeat (5) begin
         tick();
         chkb("post_rst_valid0", rsp_valid[0], 1'b0);
         chkb("post_rst_valid1", rsp_valid[1], 1'b0);
      end
      fetch(0, 32'h8000_0008, 32'h0020_0113, 1'b0);
      retire(0);
      fetch(1, 32'h8000_0008, 32'h0020_0113, 1'b0);
      retire(1);

      tick();
      chk("sb0_empty", sb0.size(), 32'd0);
      chk("sb1_empty", sb1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
